// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : Shared types and constants for the data-memory responder:
//               FSM state encoding, data word width and wait-counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    // Width of one data word and of the request/response data buses
    localparam int unsigned c_word_w     = 32;

    // Width of the wait-state down-counter (covers WAIT_CYCLES 0..15)
    localparam int unsigned c_wait_cnt_w = 4;

    // Responder FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dmem_state_e;

endpackage : dmem_pkg
`default_nettype wire

// File: rtl/dmem_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_if
// Description : Data-memory port between datapath (master) and responder
//               (slave): valid/ready request channel plus a one-cycle
//               response pulse with no backpressure.
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_if;
    import dmem_pkg::*;

    logic                req_valid;
    logic                req_write;
    logic [31:0]         req_addr;
    logic [c_word_w-1:0] req_wdata;
    logic                req_ready;
    logic                rsp_valid;
    logic [c_word_w-1:0] rsp_rdata;
    logic                rsp_err;
    logic                busy;

    // Datapath side: issues requests, samples the response pulse
    modport master (
        output req_valid,
        output req_write,
        output req_addr,
        output req_wdata,
        input  req_ready,
        input  rsp_valid,
        input  rsp_rdata,
        input  rsp_err,
        input  busy
    );

    // Memory side: accepts requests, produces the response pulse
    modport slave (
        input  req_valid,
        input  req_write,
        input  req_addr,
        input  req_wdata,
        output req_ready,
        output rsp_valid,
        output rsp_rdata,
        output rsp_err,
        output busy
    );

endinterface : dmem_if
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
// Module      : dmem_array
// Description : DEPTH_WORDS x 32-bit word storage. Synchronous write with
//               write enable, asynchronous (combinational) read on the same
//               address. Contents are zero at time zero and never reset.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_array
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned ADDR_W      = $clog2(DEPTH_WORDS)
) (
    input  wire logic                clk,
    input  wire logic                we,
    input  wire logic [ADDR_W-1:0]   addr,
    input  wire logic [c_word_w-1:0] wdata,
    output      logic [c_word_w-1:0] rdata
);

    logic [c_word_w-1:0] mem [DEPTH_WORDS] = '{default: '0};

    // Store commit: one word per enabled clock edge
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule : dmem_array
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Responder end of the processor data-memory port. Accepts one
//               load/store at a time, inserts WAIT_CYCLES wait states for
//               legal accesses, rejects out-of-range (and optionally
//               misaligned) accesses with an error response, and returns a
//               registered one-cycle response pulse.
//               Build option: define DMEM_ALIGN_CHECK_EN to reject accesses
//               with req_addr[1:0] != 0; otherwise the low address bits are
//               ignored and the access truncates to the containing word.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  wire logic clk,
    input  wire logic rst,
    dmem_if.slave     bus
);

    localparam int unsigned ADDR_W = $clog2(DEPTH_WORDS);

    // Counter preload: WAIT spans exactly WAIT_CYCLES cycles
    localparam logic [c_wait_cnt_w-1:0] c_wait_init =
        (WAIT_CYCLES == 0) ? '0 : c_wait_cnt_w'(WAIT_CYCLES - 1);

    // With no wait states the array is accessed on the acceptance edge
    localparam bit c_zero_wait = (WAIT_CYCLES == 0);

    // ------------------------------------------------------------------
    // State and registered request/response fields
    // ------------------------------------------------------------------
    dmem_state_e             state_q,     state_d;
    logic [c_wait_cnt_w-1:0] cnt_q,       cnt_d;
    logic                    wr_q,        wr_d;
    logic [31:0]             addr_q,      addr_d;
    logic [c_word_w-1:0]     wdata_q,     wdata_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic                    rsp_err_q,   rsp_err_d;
    logic [c_word_w-1:0]     rsp_rdata_q, rsp_rdata_d;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic                w_accept;
    logic                w_out_of_range;
    logic                w_misaligned;
    logic                w_illegal;
    logic [ADDR_W-1:0]   w_req_word;

    // Array port
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [c_word_w-1:0] mem_wdata;
    logic [c_word_w-1:0] mem_rdata;

    // Address bits that never select a word are latched but not consumed
    logic                unused_addr_bits;

    assign w_accept       = (state_q == ST_IDLE) && bus.req_valid;
    assign w_out_of_range = ({1'b0, bus.req_addr[31:2]} >= 31'(DEPTH_WORDS));
    assign w_req_word     = bus.req_addr[ADDR_W+1:2];

`ifdef DMEM_ALIGN_CHECK_EN
    assign w_misaligned   = (bus.req_addr[1:0] != 2'b00);
`else
    assign w_misaligned   = 1'b0;
`endif

    assign w_illegal        = w_out_of_range | w_misaligned;
    assign unused_addr_bits = ^{addr_q[1:0], addr_q[31:ADDR_W+2], bus.req_addr[1:0]};

    // Array port steering: commit/read from the latched request on the last
    // WAIT cycle, or straight from the bus when there are no wait states
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = addr_q[ADDR_W+1:2];
        mem_wdata = wdata_q;
        if ((state_q == ST_WAIT) && (cnt_q == '0)) begin
            mem_we = wr_q;
        end else if (c_zero_wait && w_accept && !w_illegal) begin
            mem_addr  = w_req_word;
            mem_wdata = bus.req_wdata;
            mem_we    = bus.req_write;
        end
    end

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .ADDR_W      (ADDR_W)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    // Next-state, counter, request latch and response data decode
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        // Response pulse trails the RESP state by one register stage
        rsp_valid_d = (state_q == ST_RESP);

        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    wr_d        = bus.req_write;
                    addr_d      = bus.req_addr;
                    wdata_d     = bus.req_wdata;
                    rsp_err_d   = w_illegal;
                    rsp_rdata_d = '0;
                    if (w_illegal) begin
                        state_d = ST_RESP;
                    end else if (c_zero_wait) begin
                        state_d = ST_RESP;
                        if (!bus.req_write) begin
                            rsp_rdata_d = mem_rdata;
                        end
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = c_wait_init;
                    end
                end
            end

            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_RESP;
                    if (!wr_q) begin
                        rsp_rdata_d = mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            ST_RESP: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register; reset discards any outstanding request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: registered or decoded from registered state only
    // ------------------------------------------------------------------
    assign bus.req_ready = (state_q == ST_IDLE);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;

endmodule : dmem_responder
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_responder
// Description : Self-checking bench for dmem_responder. Instance A uses
//               WAIT_CYCLES=2, instance B uses WAIT_CYCLES=0. Expected
//               responses (data, error, arrival cycle) are queued at
//               acceptance and compared when rsp_valid pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int W_A = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_if if_a ();
    dmem_if if_b ();

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(W_A)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (if_a.slave)
    );

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (if_b.slave)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          exp_cyc;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t mon_a;
    exp_t mon_b;
    int   n_checks = 0;
    int   n_errors = 0;

    // Scoreboard for instance A
    always @(negedge clk) begin
        if (!rst && if_a.rsp_valid) begin
            if (q_a.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL a_unexpected_rsp: rsp_valid=1 at cycle %0d, required no response", cyc);
            end else begin
                mon_a = q_a.pop_front();
                n_checks++;
                if (if_a.rsp_rdata !== mon_a.rdata) begin
                    n_errors++;
                    $display("FAIL a_rdata: got %h, required %h", if_a.rsp_rdata, mon_a.rdata);
                end
                n_checks++;
                if (if_a.rsp_err !== mon_a.err) begin
                    n_errors++;
                    $display("FAIL a_err: got %b, required %b", if_a.rsp_err, mon_a.err);
                end
                n_checks++;
                if (cyc !== mon_a.exp_cyc) begin
                    n_errors++;
                    $display("FAIL a_latency: rsp at cycle %0d, required cycle %0d", cyc, mon_a.exp_cyc);
                end
            end
        end
    end

    // Scoreboard for instance B
    always @(negedge clk) begin
        if (!rst && if_b.rsp_valid) begin
            if (q_b.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL b_unexpected_rsp: rsp_valid=1 at cycle %0d, required no response", cyc);
            end else begin
                mon_b = q_b.pop_front();
                n_checks++;
                if (if_b.rsp_rdata !== mon_b.rdata) begin
                    n_errors++;
                    $display("FAIL b_rdata: got %h, required %h", if_b.rsp_rdata, mon_b.rdata);
                end
                n_checks++;
                if (if_b.rsp_err !== mon_b.err) begin
                    n_errors++;
                    $display("FAIL b_err: got %b, required %b", if_b.rsp_err, mon_b.err);
                end
                n_checks++;
                if (cyc !== mon_b.exp_cyc) begin
                    n_errors++;
                    $display("FAIL b_latency: rsp at cycle %0d, required cycle %0d", cyc, mon_b.exp_cyc);
                end
            end
        end
    end

    // Issue one request (called at a negedge); queues its expected response
    task automatic do_req(input bit sel, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rdata,
                          input logic exp_err, output int acc_cyc);
        int   n;
        int   lat;
        exp_t e;
        lat = exp_err ? 1 : (sel ? 1 : W_A + 1);
        if (sel) begin
            if_b.req_valid = 1'b1; if_b.req_write = wr; if_b.req_addr = addr; if_b.req_wdata = wdata;
        end else begin
            if_a.req_valid = 1'b1; if_a.req_write = wr; if_a.req_addr = addr; if_a.req_wdata = wdata;
        end
        n = 0;
        while (!(sel ? if_b.req_ready : if_a.req_ready) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            n_checks++;
            n_errors++;
            $display("FAIL accept_timeout: req_ready stayed 0 for %0d cycles, required 1", n);
            acc_cyc = -1;
        end else begin
            acc_cyc   = cyc + 1;
            e.rdata   = exp_rdata;
            e.err     = exp_err;
            e.exp_cyc = acc_cyc + lat;
            if (sel) q_b.push_back(e); else q_a.push_back(e);
            @(negedge clk);
        end
        if (sel) if_b.req_valid = 1'b0; else if_a.req_valid = 1'b0;
    endtask

    // Wait until every queued response has arrived and the DUT is idle
    task automatic drain(input bit sel);
        int n;
        n = 0;
        while (((sel ? q_b.size() : q_a.size()) != 0 ||
                (sel ? if_b.busy : if_a.busy) ||
                (sel ? if_b.rsp_valid : if_a.rsp_valid)) && n < 40) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (n >= 40) begin
            n_errors++;
            $display("FAIL drain_timeout: %0d responses pending, required 0",
                     sel ? q_b.size() : q_a.size());
            if (sel) q_b.delete(); else q_a.delete();
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (if_a.req_ready !== 1'b1) begin n_errors++; $display("FAIL reset_req_ready: got %b, required 1", if_a.req_ready); end
        n_checks++; if (if_a.rsp_valid !== 1'b0) begin n_errors++; $display("FAIL reset_rsp_valid: got %b, required 0", if_a.rsp_valid); end
        n_checks++; if (if_a.rsp_err !== 1'b0)   begin n_errors++; $display("FAIL reset_rsp_err: got %b, required 0", if_a.rsp_err); end
        n_checks++; if (if_a.busy !== 1'b0)      begin n_errors++; $display("FAIL reset_busy: got %b, required 0", if_a.busy); end
        n_checks++; if (if_a.rsp_rdata !== 32'h0) begin n_errors++; $display("FAIL reset_rsp_rdata: got %h, required 0", if_a.rsp_rdata); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_store_load();
        int acc;
        do_req(0, 1'b1, 32'h3FC, 32'h0BADF00D, 32'h0, 1'b0, acc);
        do_req(0, 1'b1, 32'h040, 32'h11112222, 32'h0, 1'b0, acc);
        do_req(0, 1'b1, 32'h020, 32'h01020304, 32'h0, 1'b0, acc);
        do_req(0, 1'b1, 32'h010, 32'hDEADBEEF, 32'h0, 1'b0, acc);
        do_req(0, 1'b0, 32'h010, 32'h0,        32'hDEADBEEF, 1'b0, acc);
        drain(0);
    endtask

    task automatic test_out_of_range();
        int acc;
        do_req(0, 1'b0, 32'h400,      32'h0,        32'h0, 1'b1, acc);
        do_req(0, 1'b0, 32'h3FC,      32'h0,        32'h0BADF00D, 1'b0, acc);
        do_req(0, 1'b1, 32'hFFFFFFF0, 32'hCAFECAFE, 32'h0, 1'b1, acc);
        do_req(0, 1'b0, 32'h3FC,      32'h0,        32'h0BADF00D, 1'b0, acc);
        drain(0);
    endtask

    task automatic test_misaligned();
        int acc;
`ifdef DMEM_ALIGN_CHECK_EN
        do_req(0, 1'b1, 32'h022, 32'hAAAA5555, 32'h0, 1'b1, acc);
        do_req(0, 1'b0, 32'h020, 32'h0, 32'h01020304, 1'b0, acc);
`else
        do_req(0, 1'b1, 32'h022, 32'hAAAA5555, 32'h0, 1'b0, acc);
        do_req(0, 1'b0, 32'h020, 32'h0, 32'hAAAA5555, 1'b0, acc);
        do_req(0, 1'b0, 32'h023, 32'h0, 32'hAAAA5555, 1'b0, acc);
`endif
        drain(0);
    endtask

    task automatic test_backpressure();
        int   n;
        int   stalls;
        exp_t e;
        if_a.req_valid = 1'b1; if_a.req_write = 1'b0; if_a.req_addr = 32'h010; if_a.req_wdata = 32'h0;
        n = 0;
        while (!if_a.req_ready && n < 50) begin @(negedge clk); n++; end
        e.rdata = 32'hDEADBEEF; e.err = 1'b0; e.exp_cyc = cyc + 1 + W_A + 1;
        q_a.push_back(e);
        stalls = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (if_a.req_ready) break;
            stalls++;
            if_a.req_addr = 32'($urandom_range(0, 255)) << 2;
        end
        if_a.req_valid = 1'b0;
        n_checks++;
        if (stalls !== W_A + 1) begin
            n_errors++;
            $display("FAIL backpressure_stall: req_ready low for %0d cycles, required %0d", stalls, W_A + 1);
        end
        drain(0);
    endtask

    task automatic test_back_to_back();
        int acc1;
        int acc2;
        do_req(0, 1'b0, 32'h010, 32'h0, 32'hDEADBEEF, 1'b0, acc1);
        do_req(0, 1'b0, 32'h040, 32'h0, 32'h11112222, 1'b0, acc2);
        n_checks++;
        if (acc2 - acc1 !== W_A + 2) begin
            n_errors++;
            $display("FAIL a_accept_spacing: %0d cycles, required %0d", acc2 - acc1, W_A + 2);
        end
        drain(0);
    endtask

    task automatic test_reset_mid_store();
        int acc;
        do_req(0, 1'b1, 32'h040, 32'h12345678, 32'h0, 1'b0, acc);
        @(negedge clk);
        rst = 1'b1;
        if (q_a.size() != 0) void'(q_a.pop_back());
        #1;
        n_checks++; if (if_a.req_ready !== 1'b1) begin n_errors++; $display("FAIL midrst_req_ready: got %b, required 1", if_a.req_ready); end
        n_checks++; if (if_a.busy !== 1'b0)      begin n_errors++; $display("FAIL midrst_busy: got %b, required 0", if_a.busy); end
        n_checks++; if (if_a.rsp_valid !== 1'b0) begin n_errors++; $display("FAIL midrst_rsp_valid: got %b, required 0", if_a.rsp_valid); end
        n_checks++; if (if_a.rsp_err !== 1'b0)   begin n_errors++; $display("FAIL midrst_rsp_err: got %b, required 0", if_a.rsp_err); end
        n_checks++; if (if_a.rsp_rdata !== 32'h0) begin n_errors++; $display("FAIL midrst_rsp_rdata: got %h, required 0", if_a.rsp_rdata); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        do_req(0, 1'b0, 32'h040, 32'h0, 32'h11112222, 1'b0, acc);
        drain(0);
    endtask

    task automatic test_zero_wait();
        int acc1;
        int acc2;
        do_req(1, 1'b1, 32'h000, 32'hA0A0A0A0, 32'h0, 1'b0, acc1);
        do_req(1, 1'b1, 32'h004, 32'hB1B1B1B1, 32'h0, 1'b0, acc1);
        do_req(1, 1'b0, 32'h400, 32'h0, 32'h0, 1'b1, acc1);
        drain(1);
        do_req(1, 1'b0, 32'h000, 32'h0, 32'hA0A0A0A0, 1'b0, acc1);
        do_req(1, 1'b0, 32'h004, 32'h0, 32'hB1B1B1B1, 1'b0, acc2);
        n_checks++;
        if (acc2 - acc1 !== 2) begin
            n_errors++;
            $display("FAIL b_accept_spacing: %0d cycles, required 2", acc2 - acc1);
        end
        drain(1);
    endtask

    initial begin
        if_a.req_valid = 1'b0; if_a.req_write = 1'b0; if_a.req_addr = '0; if_a.req_wdata = '0;
        if_b.req_valid = 1'b0; if_b.req_write = 1'b0; if_b.req_addr = '0; if_b.req_wdata = '0;
        test_reset();
        test_store_load();
        test_out_of_range();
        test_misaligned();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_store();
        test_zero_wait();
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t, required completion", $time);
        $fatal(1, "timeout");
    end

endmodule : tb_dmem_responder
`default_nettype wire
